// File: rtl/wb_arbiter_pkg.sv
// Shared core widths and the write-port grant encoding for the write-back arbiter.
// The widths and write-enable level are the core-wide instWidth/regAddrWidth/funEnable values.
`timescale 1ns/1ps
package wb_arbiter_pkg;

    localparam int   INST_WIDTH     = 32;
    localparam int   REG_ADDR_WIDTH = 5;
    localparam logic FUN_ENABLE     = 1'b1;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

    // x0 is hard-wired zero, so it never counts as a pending destination.
    function automatic logic addr_hit(input logic [REG_ADDR_WIDTH-1:0] entry,
                                      input logic [REG_ADDR_WIDTH-1:0] query);
        return (entry == query) && (query != {REG_ADDR_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for FFT/IFFT results, exposing per-entry valid/address for the
// decode hazard lookup. Push while full and pop while empty are ignored.
`timescale 1ns/1ps
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push,
    input  logic [REG_ADDR_WIDTH-1:0]             push_addr,
    input  logic [INST_WIDTH-1:0]                 push_data,
    input  logic                                  pop,
    output logic [REG_ADDR_WIDTH-1:0]             head_addr,
    output logic [INST_WIDTH-1:0]                 head_data,
    output logic [CW-1:0]                         count,
    output logic                                  full,
    output logic                                  empty,
    output logic [DEPTH-1:0]                      entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0]  entry_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [REG_ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [INST_WIDTH-1:0]     data_mem [DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic                      do_push;
    logic                      do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == {CW{1'b0}});
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= {REG_ADDR_WIDTH{1'b0}};
                data_mem[i] <= {INST_WIDTH{1'b0}};
            end
        end else if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PW-1:0] offset;
        // An entry is live when its distance from the head is below the occupancy.
        assign offset         = PW'(g) - rd_ptr;
        assign entry_valid[g] = ({1'b0, offset} < count);
        assign entry_addr[g]  = addr_mem[g];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU write-back has priority, FFT/IFFT results are
// queued and drained into idle cycles, with a periodic forced ALU stall against starvation.
`timescale 1ns/1ps
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alu_wena,
    input  logic [REG_ADDR_WIDTH-1:0]         alu_waddr,
    input  logic [INST_WIDTH-1:0]             alu_wdata,
    input  logic                              fu_valid,
    output logic                              fu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]         fu_waddr,
    input  logic [INST_WIDTH-1:0]             fu_wdata,
    output logic                              alu_stall,
    output logic                              reg_wena,
    output logic [REG_ADDR_WIDTH-1:0]         reg_waddr,
    output logic [INST_WIDTH-1:0]             reg_wdata,
    input  logic [REG_ADDR_WIDTH-1:0]         lookup_addr,
    output logic                              lookup_hit,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    grant_e                                 grant;
    logic                                   alu_req;
    logic                                   fu_push;
    logic                                   fifo_pop;
    logic                                   fifo_full;
    logic                                   fifo_empty;
    logic [REG_ADDR_WIDTH-1:0]              head_addr;
    logic [INST_WIDTH-1:0]                  head_data;
    logic [FIFO_DEPTH-1:0]                  entry_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0] entry_addr;
    logic [SW-1:0]                          starve_cnt;
    logic [SW-1:0]                          starve_inc;
    logic [SW-1:0]                          starve_next;
    logic                                   stall_next;

    // A full FIFO refuses the handshake even if it pops this cycle; x0 results are dropped.
    assign fu_ready = !fifo_full;
    assign fu_push  = fu_valid && !fifo_full && (fu_waddr != {REG_ADDR_WIDTH{1'b0}});
    assign alu_req  = alu_wena && !alu_stall && (alu_waddr != {REG_ADDR_WIDTH{1'b0}});
    assign fifo_pop = (grant == GRANT_FIFO);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fu_push),
        .push_addr   (fu_waddr),
        .push_data   (fu_wdata),
        .pop         (fifo_pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Port grant: ALU first, otherwise the FIFO head from registered occupancy (no bypass).
    always_comb begin
        grant = GRANT_NONE;
        if (alu_req) begin
            grant = GRANT_ALU;
        end else if (!fifo_empty) begin
            grant = GRANT_FIFO;
        end else begin
            grant = GRANT_NONE;
        end
    end

    // Starvation accounting: count ALU wins over a waiting FIFO, fire one stall at the limit.
    always_comb begin
        starve_next = {SW{1'b0}};
        stall_next  = 1'b0;
        starve_inc  = starve_cnt + SW'(1);
        if ((grant == GRANT_ALU) && !fifo_empty) begin
            if (starve_inc == SW'(STARVE_LIMIT)) begin
                stall_next  = 1'b1;
                starve_next = {SW{1'b0}};
            end else begin
                starve_next = starve_inc;
            end
        end else begin
            starve_next = {SW{1'b0}};
        end
    end

    // Starvation counter and the registered stall it produces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= {SW{1'b0}};
            alu_stall  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            alu_stall  <= stall_next;
        end
    end

    // Output register; address and data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wena  <= 1'b0;
            reg_waddr <= {REG_ADDR_WIDTH{1'b0}};
            reg_wdata <= {INST_WIDTH{1'b0}};
        end else begin
            case (grant)
                GRANT_ALU: begin
                    reg_wena  <= FUN_ENABLE;
                    reg_waddr <= alu_waddr;
                    reg_wdata <= alu_wdata;
                end
                GRANT_FIFO: begin
                    reg_wena  <= FUN_ENABLE;
                    reg_waddr <= head_addr;
                    reg_wdata <= head_data;
                end
                default: begin
                    reg_wena  <= 1'b0;
                end
            endcase
        end
    end

    // Pending-write lookup over live FIFO entries and the output register.
    always_comb begin
        lookup_hit = reg_wena && addr_hit(reg_waddr, lookup_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            lookup_hit = lookup_hit | (entry_valid[i] && addr_hit(entry_addr[i], lookup_addr));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register writes and stall cycles are queued by the
// stimulus and popped by an independent monitor whenever the DUT presents them.
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_wena;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        fu_valid;
    logic        fu_ready;
    logic [4:0]  fu_waddr;
    logic [31:0] fu_wdata;
    logic        alu_stall;
    logic        reg_wena;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [4:0]  lookup_addr;
    logic        lookup_hit;
    logic [1:0]  fifo_count;

    wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wena(alu_wena), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_waddr(fu_waddr), .fu_wdata(fu_wdata),
        .alu_stall(alu_stall), .reg_wena(reg_wena), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cycle;
    } wr_t;

    wr_t exp_q[$];
    int  stall_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  t;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
        wr_t e;
        e.addr  = a;
        e.data  = d;
        e.cycle = c;
        exp_q.push_back(e);
    endtask

    // Apply inputs for the current cycle, then advance to just after the next rising edge.
    task automatic drive(input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                         input logic fv, input logic [4:0] fa, input logic [31:0] fd);
        alu_wena  = ae;
        alu_waddr = aa;
        alu_wdata = ad;
        fu_valid  = fv;
        fu_waddr  = fa;
        fu_wdata  = fd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic chk_lookup(input logic [4:0] a, input logic exp, input string name);
        lookup_addr = a;
        #1;
        check(name, 64'(lookup_hit), 64'(exp));
    endtask

    // Monitor: every presented write or stall must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wena) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got x%0d=%0h at cycle %0d, expected no write",
                             reg_waddr, reg_wdata, cyc);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(reg_waddr), 64'(e.addr));
                    check("wr_data", 64'(reg_wdata), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.cycle));
                end
            end
            if (alu_stall) begin
                if (stall_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_stall: got alu_stall=1 at cycle %0d, expected 0", cyc);
                end else begin
                    int s;
                    s = stall_q.pop_front();
                    check("stall_cycle", 64'(cyc), 64'(s));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        alu_wena    = 1'b0;
        alu_waddr   = 5'd0;
        alu_wdata   = 32'd0;
        fu_valid    = 1'b0;
        fu_waddr    = 5'd0;
        fu_wdata    = 32'd0;
        lookup_addr = 5'd5;
        #3;
        check("rst_alu_stall", 64'(alu_stall), 64'd0);
        check("rst_reg_wena", 64'(reg_wena), 64'd0);
        check("rst_reg_waddr", 64'(reg_waddr), 64'd0);
        check("rst_reg_wdata", 64'(reg_wdata), 64'd0);
        check("rst_fu_ready", 64'(fu_ready), 64'd1);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_lookup", 64'(lookup_hit), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // ALU-only writes land one cycle after the request.
        t = cyc;
        expect_wr(5'd5, 32'h11, t + 1);
        expect_wr(5'd6, 32'h22, t + 2);
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 32'd0);
        chk_lookup(5'd6, 1'b1, "lookup_outreg_alu");
        idle(3);
        chk_lookup(5'd6, 1'b0, "lookup_after_write");

        // Single FU result drains two cycles after its push.
        t = cyc;
        expect_wr(5'd7, 32'hA5A5, t + 2);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5);
        check("fu_count_after_push", 64'(fifo_count), 64'd1);
        chk_lookup(5'd7, 1'b1, "lookup_queued_x7");
        idle(1);
        check("fu_count_after_pop", 64'(fifo_count), 64'd0);
        chk_lookup(5'd7, 1'b1, "lookup_outreg_x7");
        idle(2);

        // Four ALU wins over a waiting entry force one stall that drains it.
        t = cyc;
        for (int i = 1; i <= 4; i++) begin
            expect_wr(5'(i), 32'h100 + 32'(i), t + 1 + i);
        end
        expect_wr(5'd8, 32'h808, t + 6);
        expect_wr(5'd12, 32'hC0C, t + 7);
        stall_q.push_back(t + 5);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h808);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
        end
        check("starve_stall_high", 64'(alu_stall), 64'd1);
        drive(1'b1, 5'd12, 32'hC0C, 1'b0, 5'd0, 32'd0);
        check("starve_stall_one_cycle", 64'(alu_stall), 64'd0);
        drive(1'b1, 5'd12, 32'hC0C, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Fill the FIFO under ALU traffic; a third result waits for space.
        t = cyc;
        expect_wr(5'd1, 32'h201, t + 1);
        expect_wr(5'd2, 32'h202, t + 2);
        expect_wr(5'd3, 32'h203, t + 3);
        expect_wr(5'd4, 32'h204, t + 4);
        expect_wr(5'd5, 32'h205, t + 5);
        expect_wr(5'd20, 32'h2020, t + 6);
        expect_wr(5'd6, 32'h206, t + 7);
        expect_wr(5'd21, 32'h2121, t + 8);
        expect_wr(5'd22, 32'h2222, t + 9);
        stall_q.push_back(t + 5);
        drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd20, 32'h2020);
        drive(1'b1, 5'd2, 32'h202, 1'b1, 5'd21, 32'h2121);
        check("full_fu_ready", 64'(fu_ready), 64'd0);
        check("full_count", 64'(fifo_count), 64'd2);
        chk_lookup(5'd20, 1'b1, "lookup_q_x20");
        chk_lookup(5'd21, 1'b1, "lookup_q_x21");
        chk_lookup(5'd0, 1'b0, "lookup_x0");
        drive(1'b1, 5'd3, 32'h203, 1'b1, 5'd22, 32'h2222);
        drive(1'b1, 5'd4, 32'h204, 1'b1, 5'd22, 32'h2222);
        drive(1'b1, 5'd5, 32'h205, 1'b1, 5'd22, 32'h2222);
        check("full_stall_high", 64'(alu_stall), 64'd1);
        check("full_no_push_through_pop", 64'(fu_ready), 64'd0);
        drive(1'b1, 5'd6, 32'h206, 1'b1, 5'd22, 32'h2222);
        check("space_fu_ready", 64'(fu_ready), 64'd1);
        check("space_count", 64'(fifo_count), 64'd1);
        drive(1'b1, 5'd6, 32'h206, 1'b1, 5'd22, 32'h2222);
        check("refill_count", 64'(fifo_count), 64'd2);
        idle(4);
        check("drained_count", 64'(fifo_count), 64'd0);

        // Writes targeting x0 are dropped on both paths.
        check("x0_fu_ready", 64'(fu_ready), 64'd1);
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        check("x0_no_wena", 64'(reg_wena), 64'd0);
        check("x0_count", 64'(fifo_count), 64'd0);
        idle(2);

        // Asynchronous reset with two results queued discards them.
        t = cyc;
        expect_wr(5'd1, 32'h301, t + 1);
        expect_wr(5'd2, 32'h302, t + 2);
        expect_wr(5'd3, 32'h303, t + 3);
        drive(1'b1, 5'd1, 32'h301, 1'b1, 5'd9, 32'h909);
        drive(1'b1, 5'd2, 32'h302, 1'b1, 5'd10, 32'h1010);
        drive(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'd0);
        check("prereset_count", 64'(fifo_count), 64'd2);
        alu_wena  = 1'b1;
        alu_waddr = 5'd4;
        alu_wdata = 32'h304;
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        alu_wena = 1'b0;
        #1;
        check("midrst_alu_stall", 64'(alu_stall), 64'd0);
        check("midrst_reg_wena", 64'(reg_wena), 64'd0);
        check("midrst_reg_waddr", 64'(reg_waddr), 64'd0);
        check("midrst_reg_wdata", 64'(reg_wdata), 64'd0);
        check("midrst_fu_ready", 64'(fu_ready), 64'd1);
        check("midrst_fifo_count", 64'(fifo_count), 64'd0);
        chk_lookup(5'd9, 1'b0, "midrst_lookup_x9");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        check("postrst_count", 64'(fifo_count), 64'd0);

        check("writes_outstanding", 64'(exp_q.size()), 64'd0);
        check("stalls_outstanding", 64'(stall_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
